// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared encodings and default sizes for the VRAM arbiter.
// Also used by the video unit and the CPU bus for RAM_SIZE/XLEN defaults.
package vram_arbiter_pkg;

    localparam int VRAM_SIZE = 8192;
    localparam int VRAM_XLEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/vram_arb_pick.sv
// vram_arb_pick: combinational grant decision, video first unless CPU starved.
// Ports: i_cpu_req/i_vid_req candidates, i_starved, o_grant, o_owner.
module vram_arb_pick
    import vram_arbiter_pkg::*;
(
    input  logic       i_cpu_req,
    input  logic       i_vid_req,
    input  logic       i_starved,
    output logic       o_grant,
    output arb_owner_t o_owner
);

    always_comb begin
        o_grant = 1'b0;
        o_owner = OWN_CPU;
        if (i_vid_req && !i_starved) begin
            o_grant = 1'b1;
            o_owner = OWN_VID;
        end else if (i_cpu_req) begin
            o_grant = 1'b1;
            o_owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port work/video RAM between CPU and video.
// Ports: cpu_*/vid_* req/ack handshakes, ram_* registered RAM port, vid_underrun.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int RAM_SIZE       = VRAM_SIZE,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int XLEN           = VRAM_XLEN,
    parameter int CPU_STARVE_MAX = 6,
    parameter int VID_DEADLINE   = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [RAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [XLEN-1:0]           cpu_wdata,
    output logic                      cpu_ack,
    output logic [XLEN-1:0]           cpu_rdata,
    input  logic                      vid_req,
    input  logic [RAM_ADDR_WIDTH-1:0] vid_addr,
    output logic                      vid_ack,
    output logic [XLEN-1:0]           vid_rdata,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_we,
    output logic [XLEN-1:0]           ram_wdata,
    input  logic [XLEN-1:0]           ram_rdata,
    output logic                      vid_underrun
);

    localparam int SW = $clog2(CPU_STARVE_MAX + 2);
    localparam int VW = $clog2(VID_DEADLINE + 2);
    localparam logic [SW-1:0] STARVE_TOP = SW'(CPU_STARVE_MAX);
    localparam logic [VW-1:0] VWAIT_TOP  = VW'(VID_DEADLINE + 1);
    localparam logic [VW-1:0] VWAIT_LIM  = VW'(VID_DEADLINE);

    arb_state_t                r_state;
    arb_owner_t                r_owner;
    logic                      r_cpu_ack;
    logic                      r_vid_ack;
    logic [XLEN-1:0]           r_cpu_rdata;
    logic [XLEN-1:0]           r_vid_rdata;
    logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
    logic                      r_ram_we;
    logic [XLEN-1:0]           r_ram_wdata;
    logic [SW-1:0]             r_starve;
    logic [VW-1:0]             r_vwait;
    logic                      r_underrun;

    logic       w_in_data;
    logic       w_arb;
    logic       w_cpu_cand;
    logic       w_vid_cand;
    logic       w_starved;
    logic       w_pick;
    arb_owner_t w_pick_own;
    logic       w_grant;
    logic       w_cpu_win;
    logic       w_cpu_owner;
    logic       w_vid_inc;

    assign w_in_data = (r_state == DATA);
    assign w_arb     = (r_state == IDLE) || w_in_data;

    // In DATA the owner's req still shows the access being completed, so it
    // yields to the other requester; alone, a held req is the next access.
    assign w_cpu_cand = cpu_req &&
        !(w_in_data && r_owner == OWN_CPU && vid_req);
    assign w_vid_cand = vid_req &&
        !(w_in_data && r_owner == OWN_VID && cpu_req);
    assign w_starved  = (r_starve >= STARVE_TOP);

    vram_arb_pick u_pick (
        .i_cpu_req (w_cpu_cand),
        .i_vid_req (w_vid_cand),
        .i_starved (w_starved),
        .o_grant   (w_pick),
        .o_owner   (w_pick_own)
    );

    assign w_grant     = w_arb && w_pick;
    assign w_cpu_win   = w_grant && (w_pick_own == OWN_CPU);
    assign w_cpu_owner = (r_state != IDLE) && (r_owner == OWN_CPU);
    assign w_vid_inc   = vid_req && !r_vid_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_cpu_ack   <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_vid_ack <= 1'b0;
            unique case (r_state)
                ISSUE: begin
                    r_state   <= DATA;
                    r_ram_we  <= 1'b0;
                    r_cpu_ack <= (r_owner == OWN_CPU);
                    r_vid_ack <= (r_owner == OWN_VID);
                end
                default: begin
                    if (w_in_data) begin
                        if (r_owner == OWN_CPU)
                            r_cpu_rdata <= ram_rdata;
                        else
                            r_vid_rdata <= ram_rdata;
                    end
                    if (w_grant) begin
                        r_state    <= ISSUE;
                        r_owner    <= w_pick_own;
                        r_ram_addr <= (w_pick_own == OWN_CPU) ?
                                      cpu_addr : vid_addr;
                        r_ram_we   <= (w_pick_own == OWN_CPU) && cpu_we;
                        r_ram_wdata <= (w_pick_own == OWN_CPU) ?
                                       cpu_wdata : '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve   <= '0;
            r_vwait    <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (!cpu_req || w_cpu_win)
                r_starve <= '0;
            else if (!w_cpu_owner && r_starve != STARVE_TOP)
                r_starve <= r_starve + SW'(1);
            if (r_vid_ack)
                r_vwait <= '0;
            else if (w_vid_inc && r_vwait != VWAIT_TOP)
                r_vwait <= r_vwait + VW'(1);
            if (w_vid_inc && r_vwait == VWAIT_LIM)
                r_underrun <= 1'b1;
        end
    end

    // Read data is live from the RAM in the ack cycle, then held.
    assign cpu_ack      = r_cpu_ack;
    assign vid_ack      = r_vid_ack;
    assign cpu_rdata    = r_cpu_ack ? ram_rdata : r_cpu_rdata;
    assign vid_rdata    = r_vid_ack ? ram_rdata : r_vid_rdata;
    assign ram_addr     = r_ram_addr;
    assign ram_we       = r_ram_we;
    assign ram_wdata    = r_ram_wdata;
    assign vid_underrun = r_underrun;

endmodule
